// File: rtl/sayeh_window_regfile.sv
// sayeh_window_regfile: windowed general register file for the SAYEH datapath.
// NUM_REGS physical registers are seen through a window of 2^LADDR_W registers
// that starts at the window pointer (wp). There are two combinational read ports
// and one write port with byte-lane enables. A clear sweep zeroes one register
// per cycle, visiting every physical register once.
// Optional build macro: RF_WRITE_BYPASS_EN. When it is defined, an accepted
// write is forwarded combinationally to any read port that addresses the same
// register.
module sayeh_window_regfile #(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 64,
    parameter int  LADDR_W  = 2,
    localparam int WP_W     = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [LADDR_W-1:0]  laddr,
    input  logic [LADDR_W-1:0]  raddr,
    output logic [DATA_W-1:0]   lout,
    output logic [DATA_W-1:0]   rout,
    input  logic                wp_add_en,
    input  logic [WP_W-1:0]     wp_add_val,
    input  logic                wp_clr,
    input  logic                clr_start,
    output logic                busy,
    output logic [WP_W-1:0]     wp
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [WP_W-1:0]   wp_q;
    logic [WP_W-1:0]   cnt;
    logic [WP_W-1:0]   phys_l;
    logic [WP_W-1:0]   phys_r;
    logic [DATA_W-1:0] be_mask;
    logic              wr_acc;

    // Expand the byte enables to a bit mask so a write is a single masked merge.
    for (genvar g = 0; g < DATA_W/8; g++) begin : g_mask
        assign be_mask[8*g +: 8] = {8{wr_be[g]}};
    end

    // The window offset wraps modulo NUM_REGS through the natural WP_W-bit add.
    assign phys_l = wp_q + WP_W'(laddr);
    assign phys_r = wp_q + WP_W'(raddr);
    // Writes arriving during a sweep are dropped, not queued.
    assign wr_acc = (state == IDLE) && (|wr_be);
    assign busy   = (state == SWEEP);
    assign wp     = wp_q;

    // Register array: the sweep clear takes priority; otherwise apply the masked write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (state == SWEEP) begin
            regs[cnt] <= '0;
        end else if (wr_acc) begin
            regs[phys_l] <= (regs[phys_l] & ~be_mask) | (wdata & be_mask);
        end
    end

    // State and sweep counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == SWEEP) begin
                cnt <= (state_nxt == IDLE) ? '0 : cnt + WP_W'(1);
            end
        end
    end

    // Next state: clr_start is accepted only in IDLE, and the sweep ends after the last register.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (clr_start) state_nxt = SWEEP;
            SWEEP: if (cnt == WP_W'(NUM_REGS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window pointer: clear wins over add. It may change in either state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
        end else if (wp_clr) begin
            wp_q <= '0;
        end else if (wp_add_en) begin
            wp_q <= wp_q + wp_add_val;
        end
    end

`ifdef RF_WRITE_BYPASS_EN
    logic [DATA_W-1:0] byp_mask;
    assign byp_mask = be_mask & {DATA_W{wr_acc}};

    // Read ports: enabled lanes of a same-cycle write to the addressed register come from wdata.
    always_comb begin
        lout = (regs[phys_l] & ~byp_mask) | (wdata & byp_mask);
        rout = regs[phys_r];
        if (phys_r == phys_l) begin
            rout = (regs[phys_r] & ~byp_mask) | (wdata & byp_mask);
        end
    end
`else
    // Read ports: stored contents only, so new data appears on the following cycle.
    always_comb begin
        lout = regs[phys_l];
        rout = regs[phys_r];
    end
`endif

endmodule

// File: tb/tb_sayeh_window_regfile.sv
// Self-checking bench for sayeh_window_regfile with the default parameters.
// A behavioural model (an array plus window pointer and sweep progress) tracks
// the expected contents. Directed table vectors, hand-written sweep and reset
// sequences, and randomized cycles are all compared against that model.
module tb_sayeh_window_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] wdata;
    logic [1:0]  wr_be;
    logic [1:0]  laddr;
    logic [1:0]  raddr;
    logic [15:0] lout;
    logic [15:0] rout;
    logic        wp_add_en;
    logic [5:0]  wp_add_val;
    logic        wp_clr;
    logic        clr_start;
    logic        busy;
    logic [5:0]  wp;

    int checks = 0;
    int failures = 0;

    // Behavioural model state.
    logic [15:0] m [64];
    logic [5:0]  mwp;
    bit          msw;
    int          midx;

    typedef struct {
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [1:0]  la;
        logic        add_en;
        logic [5:0]  add_val;
        logic        wclr;
        logic [1:0]  rd;
        logic [15:0] exp_r;
        logic [5:0]  exp_wp;
    } vec_t;

    vec_t vt [10];

    always #5 clk = ~clk;

    sayeh_window_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wdata     (wdata),
        .wr_be     (wr_be),
        .laddr     (laddr),
        .raddr     (raddr),
        .lout      (lout),
        .rout      (rout),
        .wp_add_en (wp_add_en),
        .wp_add_val(wp_add_val),
        .wp_clr    (wp_clr),
        .clr_start (clr_start),
        .busy      (busy),
        .wp        (wp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mread(input logic [1:0] a);
        logic [5:0]  p;
        logic [15:0] v;
        p = mwp + 6'(a);
        v = m[p];
`ifdef RF_WRITE_BYPASS_EN
        if (!msw && p == 6'(mwp + 6'(laddr))) begin
            for (int i = 0; i < 2; i++)
                if (wr_be[i]) v[8*i +: 8] = wdata[8*i +: 8];
        end
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m[i] = 16'h0;
        mwp  = 6'd0;
        msw  = 1'b0;
        midx = 0;
    endtask

    task automatic model_step();
        logic [5:0] p;
        if (msw) begin
            m[midx] = 16'h0;
            midx++;
            if (midx == 64) begin
                msw  = 1'b0;
                midx = 0;
            end
        end else begin
            p = mwp + 6'(laddr);
            for (int i = 0; i < 2; i++)
                if (wr_be[i]) m[p][8*i +: 8] = wdata[8*i +: 8];
            if (clr_start) msw = 1'b1;
        end
        if (wp_clr) mwp = 6'd0;
        else if (wp_add_en) mwp = mwp + wp_add_val;
    endtask

    task automatic model_check();
        chk("lout", 32'(lout), 32'(mread(laddr)));
        chk("rout", 32'(rout), 32'(mread(raddr)));
        chk("wp", 32'(wp), 32'(mwp));
        chk("busy", 32'(busy), 32'(msw));
    endtask

    // One clock cycle with the inputs the caller has already driven.
    task automatic cyc();
        #1;
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        wr_be      = 2'b00;
        wp_add_en  = 1'b0;
        wp_add_val = 6'd0;
        wp_clr     = 1'b0;
        clr_start  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    int busy_cycles;
    int guard;

    initial begin
        wdata = 16'h0;
        laddr = 2'd0;
        raddr = 2'd0;
        idle();
        do_reset();

        // Reset state.
        chk("reset_lout", 32'(lout), 32'h0);
        chk("reset_rout", 32'(rout), 32'h0);
        chk("reset_wp", 32'(wp), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Directed vectors: one stimulus cycle, then read back raddr=rd.
        vt[0] = '{16'hABCD, 2'b11, 2'd1, 1'b0, 6'd0,  1'b0, 2'd1, 16'hABCD, 6'd0};
        vt[1] = '{16'h1234, 2'b01, 2'd1, 1'b0, 6'd0,  1'b0, 2'd1, 16'hAB34, 6'd0};
        vt[2] = '{16'h5600, 2'b10, 2'd1, 1'b0, 6'd0,  1'b0, 2'd1, 16'h5634, 6'd0};
        vt[3] = '{16'h1111, 2'b11, 2'd3, 1'b0, 6'd0,  1'b0, 2'd3, 16'h1111, 6'd0};
        vt[4] = '{16'h0000, 2'b00, 2'd0, 1'b1, 6'd2,  1'b0, 2'd1, 16'h1111, 6'd2};
        vt[5] = '{16'h0000, 2'b00, 2'd0, 1'b1, 6'd61, 1'b0, 2'd0, 16'h0000, 6'd63};
        vt[6] = '{16'h2222, 2'b11, 2'd2, 1'b0, 6'd0,  1'b0, 2'd2, 16'h2222, 6'd63};
        vt[7] = '{16'h0000, 2'b00, 2'd0, 1'b0, 6'd0,  1'b1, 2'd1, 16'h2222, 6'd0};
        vt[8] = '{16'hBEEF, 2'b11, 2'd0, 1'b1, 6'd4,  1'b0, 2'd0, 16'h0000, 6'd4};
        vt[9] = '{16'h0000, 2'b00, 2'd0, 1'b1, 6'd60, 1'b0, 2'd0, 16'hBEEF, 6'd0};
        for (int i = 0; i < 10; i++) begin
            wdata = vt[i].wdata; wr_be = vt[i].be; laddr = vt[i].la;
            raddr = vt[i].rd; wp_add_en = vt[i].add_en;
            wp_add_val = vt[i].add_val; wp_clr = vt[i].wclr;
            cyc();
            idle();
            laddr = vt[i].rd;
            raddr = vt[i].rd;
            #1;
            chk($sformatf("vec%0d_rout", i), 32'(rout), 32'(vt[i].exp_r));
            chk($sformatf("vec%0d_wp", i), 32'(wp), 32'(vt[i].exp_wp));
        end

        // Bypass: clear R[0], then write the low lane with 0x00FF at laddr=raddr=0.
        idle();
        wdata = 16'h0000; wr_be = 2'b11; laddr = 2'd0; raddr = 2'd0;
        cyc();
        wdata = 16'h00FF; wr_be = 2'b01;
        #1;
`ifdef RF_WRITE_BYPASS_EN
        chk("bypass_same_cycle", 32'(rout), 32'h00FF);
`else
        chk("bypass_same_cycle", 32'(rout), 32'h0000);
`endif
        cyc();
        idle();
        #1;
        chk("bypass_next_cycle", 32'(rout), 32'h00FF);

        // Fill all registers with nonzero data, stepping the window by one per write.
        for (int k = 0; k < 64; k++) begin
            wdata = 16'(k * 16'h0101 + 16'h1001); wr_be = 2'b11; laddr = 2'd0;
            raddr = 2'(k); wp_add_en = 1'b1; wp_add_val = 6'd1;
            cyc();
        end
        idle();
        clr_start = 1'b1;
        cyc();
        idle();
        busy_cycles = 0;
        guard = 0;
        #1;
        while (busy && guard < 200) begin
            busy_cycles++;
            if (busy_cycles == 20) begin
                wdata = 16'hDEAD; wr_be = 2'b11; laddr = 2'd3; clr_start = 1'b1;
            end else begin
                idle();
            end
            cyc();
            guard++;
        end
        idle();
        chk("sweep_busy_cycles", 32'(busy_cycles), 32'd64);
        laddr = 2'd3; raddr = 2'd3;
        #1;
        chk("dropped_write_target", 32'(rout), 32'h0);
        for (int k = 0; k < 64; k++) begin
            laddr = 2'd0; raddr = 2'd1; wp_add_en = 1'b1; wp_add_val = 6'd1;
            #1;
            chk($sformatf("cleared_r%0d", k), 32'(lout), 32'h0);
            cyc();
        end
        idle();

        // Second sweep aborted by reset at cycle 10.
        clr_start = 1'b1; wp_add_en = 1'b1; wp_add_val = 6'd5;
        cyc();
        idle();
        repeat (10) cyc();
        chk("sweep2_busy_before_reset", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_wp", 32'(wp), 32'h0);
        chk("abort_lout", 32'(lout), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized cycles against the model.
        for (int n = 0; n < 600; n++) begin
            wdata      = 16'($urandom);
            wr_be      = 2'($urandom);
            laddr      = 2'($urandom);
            raddr      = 2'($urandom);
            wp_add_en  = ($urandom_range(0, 3) == 0);
            wp_add_val = 6'($urandom);
            wp_clr     = ($urandom_range(0, 15) == 0);
            clr_start  = ($urandom_range(0, 60) == 0);
            cyc();
        end
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
